// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI field widths, response codes and arbiter FSM encoding
package axi_pkg;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'd0;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'd1;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'd2;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin picker, purely combinational
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o
);

    // On contention the master that did not own the port last time wins.
    always_comb begin
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - two-master AXI write arbiter, one transaction outstanding
module axi_write_arbiter
    import axi_pkg::*;
#(
    parameter int buswidth = 32,
    parameter int NUM_M    = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ID_W-1:0]       m0_AWID,    m1_AWID,
    input  logic [ADDR_W-1:0]     m0_AWADDR,  m1_AWADDR,
    input  logic [LEN_W-1:0]      m0_AWLEN,   m1_AWLEN,
    input  logic [SIZE_W-1:0]     m0_AWSIZE,  m1_AWSIZE,
    input  logic [BURST_W-1:0]    m0_AWBURST, m1_AWBURST,
    input  logic [LOCK_W-1:0]     m0_AWLOCK,  m1_AWLOCK,
    input  logic [CACHE_W-1:0]    m0_AWCACHE, m1_AWCACHE,
    input  logic [PROT_W-1:0]     m0_AWPROT,  m1_AWPROT,
    input  logic                  m0_AWVALID, m1_AWVALID,
    output logic                  m0_AWREADY, m1_AWREADY,
    input  logic [ID_W-1:0]       m0_WID,     m1_WID,
    input  logic [buswidth-1:0]   m0_WDATA,   m1_WDATA,
    input  logic [buswidth/8-1:0] m0_WSTRB,   m1_WSTRB,
    input  logic                  m0_WLAST,   m1_WLAST,
    input  logic                  m0_WVALID,  m1_WVALID,
    output logic                  m0_WREADY,  m1_WREADY,
    output logic [ID_W-1:0]       m0_BID,     m1_BID,
    output logic [RESP_W-1:0]     m0_BRESP,   m1_BRESP,
    output logic                  m0_BVALID,  m1_BVALID,
    input  logic                  m0_BREADY,  m1_BREADY,
    output logic [ID_W-1:0]       S_AWID,
    output logic [ADDR_W-1:0]     S_AWADDR,
    output logic [LEN_W-1:0]      S_AWLEN,
    output logic [SIZE_W-1:0]     S_AWSIZE,
    output logic [BURST_W-1:0]    S_AWBURST,
    output logic [LOCK_W-1:0]     S_AWLOCK,
    output logic [CACHE_W-1:0]    S_AWCACHE,
    output logic [PROT_W-1:0]     S_AWPROT,
    output logic                  S_AWVALID,
    input  logic                  S_AWREADY,
    output logic [ID_W-1:0]       S_WID,
    output logic [buswidth-1:0]   S_WDATA,
    output logic [buswidth/8-1:0] S_WSTRB,
    output logic                  S_WLAST,
    output logic                  S_WVALID,
    input  logic                  S_WREADY,
    input  logic [ID_W-1:0]       S_BID,
    input  logic [RESP_W-1:0]     S_BRESP,
    input  logic                  S_BVALID,
    output logic                  S_BREADY,
    output logic                  grant,
    output logic                  busy,
    output logic                  len_err
);

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               len_err_q, len_err_d;
    logic               arb_grant;
    logic               g_wlast;
    logic               last_beat;

    rr_arbiter2 u_arb (
        .req_i        ({m1_AWVALID, m0_AWVALID}),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant)
    );

    assign last_beat = (cnt_q == len_q);
    assign g_wlast   = grant_q ? m1_WLAST : m0_WLAST;

    // Status outputs are forced low while reset is held, even mid-burst.
    assign grant   = ARESET ? 1'b0 : grant_q;
    assign busy    = ~ARESET && (state_q != ST_IDLE);
    assign len_err = ARESET ? 1'b0 : len_err_q;

    // State, ownership and burst tracking registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'(NUM_M - 1);
            cnt_q        <= '0;
            len_q        <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            len_err_q    <= len_err_d;
        end
    end

    // Next-state logic plus channel muxing toward the granted master only.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        len_err_d    = len_err_q;
        S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0;
        S_AWLOCK = '0; S_AWCACHE = '0; S_AWPROT = '0; S_AWVALID = 1'b0;
        S_WID = '0; S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0;
        S_BREADY = 1'b0;
        m0_AWREADY = 1'b0; m1_AWREADY = 1'b0;
        m0_WREADY  = 1'b0; m1_WREADY  = 1'b0;
        m0_BID = '0; m0_BRESP = '0; m0_BVALID = 1'b0;
        m1_BID = '0; m1_BRESP = '0; m1_BVALID = 1'b0;
        if (!ARESET) begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_AWVALID || m1_AWVALID) begin
                        grant_d = arb_grant;
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    S_AWID    = grant_q ? m1_AWID    : m0_AWID;
                    S_AWADDR  = grant_q ? m1_AWADDR  : m0_AWADDR;
                    S_AWLEN   = grant_q ? m1_AWLEN   : m0_AWLEN;
                    S_AWSIZE  = grant_q ? m1_AWSIZE  : m0_AWSIZE;
                    S_AWBURST = grant_q ? m1_AWBURST : m0_AWBURST;
                    S_AWLOCK  = grant_q ? m1_AWLOCK  : m0_AWLOCK;
                    S_AWCACHE = grant_q ? m1_AWCACHE : m0_AWCACHE;
                    S_AWPROT  = grant_q ? m1_AWPROT  : m0_AWPROT;
                    S_AWVALID = grant_q ? m1_AWVALID : m0_AWVALID;
                    m0_AWREADY = ~grant_q & S_AWREADY;
                    m1_AWREADY =  grant_q & S_AWREADY;
                    if (S_AWVALID && S_AWREADY) begin
                        len_d   = S_AWLEN;
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    S_WID    = grant_q ? m1_WID    : m0_WID;
                    S_WDATA  = grant_q ? m1_WDATA  : m0_WDATA;
                    S_WSTRB  = grant_q ? m1_WSTRB  : m0_WSTRB;
                    S_WVALID = grant_q ? m1_WVALID : m0_WVALID;
                    S_WLAST  = last_beat;
                    m0_WREADY = ~grant_q & S_WREADY;
                    m1_WREADY =  grant_q & S_WREADY;
                    if (S_WVALID && S_WREADY) begin
                        if (g_wlast != last_beat) begin
                            len_err_d = 1'b1;
                        end
                        if (last_beat) begin
                            state_d = ST_RESP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    S_BREADY = grant_q ? m1_BREADY : m0_BREADY;
                    if (grant_q) begin
                        m1_BID = S_BID; m1_BRESP = S_BRESP; m1_BVALID = S_BVALID;
                    end else begin
                        m0_BID = S_BID; m0_BRESP = S_BRESP; m0_BVALID = S_BVALID;
                    end
                    if (S_BVALID && S_BREADY) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - self-checking bench for axi_write_arbiter
module tb_axi_write_arbiter;
    import axi_pkg::*;

    localparam int BW = 32;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    logic [3:0]      m_awid[2];
    logic [31:0]     m_awaddr[2];
    logic [3:0]      m_awlen[2];
    logic [2:0]      m_awsize[2];
    logic [1:0]      m_awburst[2];
    logic [1:0]      m_awlock[2];
    logic [3:0]      m_awcache[2];
    logic [2:0]      m_awprot[2];
    logic            m_awvalid[2];
    logic            m_awready[2];
    logic [3:0]      m_wid[2];
    logic [BW-1:0]   m_wdata[2];
    logic [BW/8-1:0] m_wstrb[2];
    logic            m_wlast[2];
    logic            m_wvalid[2];
    logic            m_wready[2];
    logic [3:0]      m_bid[2];
    logic [1:0]      m_bresp[2];
    logic            m_bvalid[2];
    logic            m_bready[2];

    logic [3:0]      S_AWID;
    logic [31:0]     S_AWADDR;
    logic [3:0]      S_AWLEN;
    logic [2:0]      S_AWSIZE;
    logic [1:0]      S_AWBURST, S_AWLOCK;
    logic [3:0]      S_AWCACHE;
    logic [2:0]      S_AWPROT;
    logic            S_AWVALID, S_AWREADY;
    logic [3:0]      S_WID;
    logic [BW-1:0]   S_WDATA;
    logic [BW/8-1:0] S_WSTRB;
    logic            S_WLAST, S_WVALID, S_WREADY;
    logic [3:0]      S_BID;
    logic [1:0]      S_BRESP;
    logic            S_BVALID, S_BREADY;
    logic            grant, busy, len_err;

    axi_write_arbiter #(.buswidth(BW), .NUM_M(2)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m0_AWID(m_awid[0]), .m1_AWID(m_awid[1]),
        .m0_AWADDR(m_awaddr[0]), .m1_AWADDR(m_awaddr[1]),
        .m0_AWLEN(m_awlen[0]), .m1_AWLEN(m_awlen[1]),
        .m0_AWSIZE(m_awsize[0]), .m1_AWSIZE(m_awsize[1]),
        .m0_AWBURST(m_awburst[0]), .m1_AWBURST(m_awburst[1]),
        .m0_AWLOCK(m_awlock[0]), .m1_AWLOCK(m_awlock[1]),
        .m0_AWCACHE(m_awcache[0]), .m1_AWCACHE(m_awcache[1]),
        .m0_AWPROT(m_awprot[0]), .m1_AWPROT(m_awprot[1]),
        .m0_AWVALID(m_awvalid[0]), .m1_AWVALID(m_awvalid[1]),
        .m0_AWREADY(m_awready[0]), .m1_AWREADY(m_awready[1]),
        .m0_WID(m_wid[0]), .m1_WID(m_wid[1]),
        .m0_WDATA(m_wdata[0]), .m1_WDATA(m_wdata[1]),
        .m0_WSTRB(m_wstrb[0]), .m1_WSTRB(m_wstrb[1]),
        .m0_WLAST(m_wlast[0]), .m1_WLAST(m_wlast[1]),
        .m0_WVALID(m_wvalid[0]), .m1_WVALID(m_wvalid[1]),
        .m0_WREADY(m_wready[0]), .m1_WREADY(m_wready[1]),
        .m0_BID(m_bid[0]), .m1_BID(m_bid[1]),
        .m0_BRESP(m_bresp[0]), .m1_BRESP(m_bresp[1]),
        .m0_BVALID(m_bvalid[0]), .m1_BVALID(m_bvalid[1]),
        .m0_BREADY(m_bready[0]), .m1_BREADY(m_bready[1]),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
        .S_AWBURST(S_AWBURST), .S_AWLOCK(S_AWLOCK), .S_AWCACHE(S_AWCACHE), .S_AWPROT(S_AWPROT),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WID(S_WID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: who owned the port last, and the sticky length-error flag.
    int              exp_last_grant;
    bit              exp_len_err;
    logic [BW-1:0]   wdat[2][16];
    logic [BW/8-1:0] wstb[2][16];
    int              bad_beat[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    // Round-robin rule: on contention the master other than the previous owner wins.
    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        if (r1) return 1;
        return 0;
    endfunction

    task automatic setup_master(input int m, input int len, input int bad);
        m_awid[m]    = 4'($urandom);
        m_awaddr[m]  = $urandom;
        m_awlen[m]   = 4'(len);
        m_awsize[m]  = 3'd2;
        m_awburst[m] = 2'd1;
        m_awlock[m]  = 2'($urandom);
        m_awcache[m] = 4'($urandom);
        m_awprot[m]  = 3'($urandom);
        bad_beat[m]  = bad;
        for (int i = 0; i < 16; i++) begin
            wdat[m][i] = $urandom;
            wstb[m][i] = 4'($urandom);
        end
        m_awvalid[m] = 1'b1;
    endtask

    task automatic aw_phase(input int m);
        int o = 1 - m;
        int n = 0;
        while (S_AWVALID !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("aw_wait_bound", 64'(n < 40), 64'd1);
        chk("grant", grant, m);
        chk("busy_addr", busy, 1);
        chk("s_awaddr", S_AWADDR, m_awaddr[m]);
        chk("s_awlen", S_AWLEN, m_awlen[m]);
        chk("s_awid", S_AWID, m_awid[m]);
        chk("s_awcache", S_AWCACHE, m_awcache[m]);
        S_AWREADY = 1'b1;
        #1;
        chk("awready_granted", m_awready[m], 1);
        chk("awready_other", m_awready[o], 0);
        tick();
        m_awvalid[m] = 1'b0;
        S_AWREADY    = 1'b0;
    endtask

    task automatic w_beat(input int m, input int b, input int stall);
        int o   = 1 - m;
        int len = int'(m_awlen[m]);
        bit lastb = (b == len);
        m_wvalid[m] = 1'b1;
        m_wdata[m]  = wdat[m][b];
        m_wstrb[m]  = wstb[m][b];
        m_wid[m]    = m_awid[m];
        m_wlast[m]  = lastb ^ (b == bad_beat[m]);
        for (int k = 0; k < stall; k++) begin
            S_WREADY = 1'b0;
            #1;
            chk("stall_s_wvalid", S_WVALID, 1);
            chk("stall_s_wdata", S_WDATA, wdat[m][b]);
            chk("stall_s_wlast", S_WLAST, lastb);
            chk("stall_wready_granted", m_wready[m], 0);
            chk("stall_wready_other", m_wready[o], 0);
            tick();
        end
        S_WREADY = 1'b1;
        #1;
        chk("s_wdata", S_WDATA, wdat[m][b]);
        chk("s_wstrb", S_WSTRB, wstb[m][b]);
        chk("s_wlast", S_WLAST, lastb);
        chk("wready_granted", m_wready[m], 1);
        chk("wready_other", m_wready[o], 0);
        if (m_wlast[m] != lastb) exp_len_err = 1'b1;
        tick();
        S_WREADY = 1'b0;
        chk("len_err", len_err, exp_len_err);
    endtask

    task automatic b_phase(input int m, input int bstall, input logic [1:0] resp);
        int o = 1 - m;
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        S_BVALID = 1'b1;
        S_BRESP  = resp;
        S_BID    = m_awid[m];
        for (int k = 0; k < bstall; k++) begin
            m_bready[m] = 1'b0;
            #1;
            chk("hold_bvalid_granted", m_bvalid[m], 1);
            chk("hold_s_bready", S_BREADY, 0);
            chk("hold_bresp", m_bresp[m], resp);
            chk("hold_bvalid_other", m_bvalid[o], 0);
            tick();
        end
        m_bready[m] = 1'b1;
        #1;
        chk("s_bready", S_BREADY, 1);
        chk("bresp", m_bresp[m], resp);
        chk("bid", m_bid[m], m_awid[m]);
        chk("bvalid_other", m_bvalid[o], 0);
        tick();
        S_BVALID    = 1'b0;
        S_BRESP     = '0;
        m_bready[m] = 1'b0;
        #1;
        chk("busy_after_resp", busy, 0);
        exp_last_grant = m;
    endtask

    task automatic do_txn(input int m, input int stall_max, input int bstall, input logic [1:0] resp);
        aw_phase(m);
        for (int b = 0; b <= int'(m_awlen[m]); b++) begin
            w_beat(m, b, $urandom_range(0, stall_max));
        end
        b_phase(m, bstall, resp);
    endtask

    initial begin
        int w;
        int mask;
        for (int m = 0; m < 2; m++) begin
            m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = '0;
            m_awburst[m] = '0; m_awlock[m] = '0; m_awcache[m] = '0; m_awprot[m] = '0;
            m_awvalid[m] = 1'b0; m_wid[m] = '0; m_wdata[m] = '0; m_wstrb[m] = '0;
            m_wlast[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0; bad_beat[m] = -1;
        end
        S_AWREADY = 1'b0; S_WREADY = 1'b0; S_BVALID = 1'b0; S_BRESP = '0; S_BID = '0;
        exp_last_grant = 1;
        exp_len_err    = 1'b0;

        // Reset state
        ARESET = 1'b1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_s_awvalid", S_AWVALID, 0);
        chk("rst_s_wlast", S_WLAST, 0);
        chk("rst_s_bready", S_BREADY, 0);
        ARESET = 1'b0;
        tick();

        // Simultaneous requests after reset: m0, then m1, then m0 again
        setup_master(0, 1, -1);
        setup_master(1, 2, -1);
        do_txn(0, 0, 0, RESP_OKAY);
        do_txn(1, 0, 0, RESP_OKAY);
        setup_master(0, 0, -1);
        setup_master(1, 1, -1);
        do_txn(0, 1, 0, RESP_EXOKAY);
        do_txn(1, 1, 0, RESP_OKAY);

        // m0 alone, 4 beats, slave always ready
        setup_master(0, 3, -1);
        do_txn(0, 0, 0, RESP_OKAY);

        // m1 single beat with the slave stalling three cycles
        setup_master(1, 0, -1);
        aw_phase(1);
        w_beat(1, 0, 3);
        b_phase(1, 0, RESP_OKAY);

        // m0 asserts WLAST early on beat 2 of 3
        setup_master(0, 2, 1);
        do_txn(0, 0, 0, RESP_OKAY);
        chk("len_err_sticky", len_err, 1);

        // SLVERR response held while m1_BREADY stays low
        setup_master(1, 1, -1);
        do_txn(1, 0, 2, RESP_SLVERR);
        chk("len_err_still_set", len_err, 1);

        // Reset mid-burst after the first of four beats
        setup_master(1, 3, -1);
        aw_phase(1);
        w_beat(1, 0, 0);
        m_wdata[1] = wdat[1][1];
        ARESET = 1'b1;
        S_WREADY = 1'b1;
        #1;
        chk("midrst_s_wvalid", S_WVALID, 0);
        chk("midrst_s_wdata", S_WDATA, 0);
        chk("midrst_wready", m_wready[1], 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_len_err", len_err, 0);
        tick();
        S_WREADY = 1'b0;
        m_wvalid[1] = 1'b0;
        ARESET = 1'b0;
        exp_last_grant = 1;
        exp_len_err    = 1'b0;
        #1;
        chk("postrst_busy", busy, 0);
        chk("postrst_len_err", len_err, 0);
        chk("postrst_s_wvalid", S_WVALID, 0);
        setup_master(0, 1, -1);
        setup_master(1, 0, -1);
        do_txn(0, 0, 0, RESP_OKAY);
        do_txn(1, 0, 0, RESP_OKAY);

        // Randomized traffic against the reference model
        for (int it = 0; it < 12; it++) begin
            mask = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++) begin
                if (mask[m]) begin
                    int len = $urandom_range(0, 3);
                    setup_master(m, len, ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1);
                end
            end
            w = pick(mask[0], mask[1], exp_last_grant);
            do_txn(w, 2, $urandom_range(0, 2), 2'($urandom));
            if (mask == 3) do_txn(1 - w, 2, $urandom_range(0, 2), 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 Parameter buswidth, default 32, WDATA width in bits on every port.
REQ-002 Parameter NUM_M, fixed 2, number of write masters sharing the one slave write port.
REQ-003 ACLK  in  1  single clock; all logic on posedge ACLK.
REQ-004 ARESET  in  1  synchronous, active-high reset.
REQ-005 m0_AW*/m1_AW* (ID 4, ADDR 32, LEN 4, SIZE 3, BURST 2, LOCK 2, CACHE 4, PROT 3, VALID 1)  in  per-master write address request.
REQ-006 m0_AWREADY/m1_AWREADY  out  1  per-master address accept.
REQ-007 m0_W*/m1_W* (ID 4, DATA buswidth, STRB buswidth/8, LAST 1, VALID 1)  in  per-master write data.
REQ-008 m0_WREADY/m1_WREADY  out  1  per-master data accept.
REQ-009 m0_B*/m1_B* (ID 4, RESP 2, VALID 1)  out  per-master write response; m*_BREADY in 1.
REQ-010 S_AW*, S_W* (same fields)  out; S_AWREADY, S_WREADY  in  1  slave-side address/data.
REQ-011 S_BID 4, S_BRESP 2, S_BVALID 1  in; S_BREADY  out  1  slave-side response.
REQ-012 grant  out  1  index of owning master, valid when busy=1; busy  out  1  transaction in progress.
REQ-013 len_err  out  1  sticky flag, WLAST disagreed with AWLEN.

Function
REQ-014 FSM states IDLE, ADDR, DATA, RESP; one transaction outstanding at a time.
REQ-015 IDLE: if any m*_AWVALID, register grant and go to ADDR next cycle; no request holds IDLE.
REQ-016 Both requesting: master != last_grant wins (round-robin); single requester wins directly.
REQ-017 ADDR: granted master's AW fields/AWVALID drive S_AW*; S_AWREADY routes only to granted master; other AWREADY=0.
REQ-018 ADDR: on S_AWVALID&&S_AWREADY latch AWLEN into len_q, clear beat counter, go to DATA.
REQ-019 DATA: granted W channel muxed to S_W*; S_WREADY routed only to granted master.
REQ-020 Beat counter (4-bit) increments on each S_WVALID&&S_WREADY; no wrap beyond len_q.
REQ-021 S_WLAST driven 1 exactly on beat where counter == len_q, independent of master WLAST.
REQ-022 Master WLAST != (counter==len_q) on an accepted beat sets len_err until reset.
REQ-023 Handshake of last beat moves DATA to RESP.
REQ-024 RESP: S_B* routed to granted master's m*_B*; S_BREADY = granted m*_BREADY.
REQ-025 On S_BVALID&&S_BREADY: last_grant <= grant, go to IDLE; new grant earliest next cycle.
REQ-026 Non-granted master sees AWREADY=WREADY=BVALID=0 in all states.
REQ-027 AWLEN=0: single beat, WLAST on first beat.
REQ-028 All outputs to slave 0 in IDLE; busy=1 in ADDR/DATA/RESP only.

Reset
REQ-029 ARESET=1 at any posedge: state IDLE, grant 0, last_grant 1 (master 0 first), counter 0, len_q 0, len_err 0.
REQ-030 All VALID/READY/LAST outputs 0 and data/ID outputs 0 while ARESET held, including mid-burst; abandoned transaction not resumed.

Structure
REQ-031 Shared package axi_pkg: state encoding, AXI field widths, BRESP codes (OKAY 0, EXOKAY 1, SLVERR 2, DECERR 3).
REQ-032 One sub-module rr_arbiter2 (2 requests, last_grant in, grant out, combinational) instantiated once.

Verification
REQ-033 m0 only, AWLEN=3, slave always ready -> grant=0, 4 beats, S_WLAST on beat 4, m0_BRESP=OKAY, IDLE.
REQ-034 m0,m1 request same cycle after reset -> m0 served first, then m1; third simultaneous request -> m0 again.
REQ-035 m1 AWLEN=0, S_WREADY low 3 cycles -> single beat held stable, S_WLAST=1, no m0 ready asserted.
REQ-036 m0 AWLEN=2 drives WLAST on beat 2 -> len_err=1, S_WLAST on beat 3, len_err stays 1.
REQ-037 ARESET pulsed in DATA after beat 1 of 4 -> next cycle IDLE, all outputs 0, len_err 0, next grant m0.
REQ-038 S_BRESP=SLVERR with m1_BREADY low 2 cycles -> S_BREADY low, m1_BVALID held, completes when BREADY rises.
